// File: rtl/match_mem_pkg.sv
// match_mem_pkg
//   Shared constants and helpers for the ping-pong keypoint/descriptor store.
//   - *_DEF           : default parameter values used by the top and bank interface
//   - calc_nl()       : number of descriptor-lane macros per bank
//   - calc_mw()       : physical macro data width (widest of lane and point field)
//   - lane_lo()       : bit offset of a descriptor lane within the stored word
package match_mem_pkg;

    localparam int POINT_W_DEF  = 30;
    localparam int DESC_W_DEF   = 256;
    localparam int LANE_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 9;
    localparam int SRAM_LAT_DEF = 1;

    function automatic int calc_nl(input int desc_w, input int lane_w);
        return desc_w / lane_w;
    endfunction

    function automatic int calc_mw(input int lane_w, input int point_w);
        return (lane_w > point_w) ? lane_w : point_w;
    endfunction

    function automatic int lane_lo(input int lane, input int lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/match_mem_bank_if.sv
// match_mem_bank_if
//   Pin interface for one physical bank: NL descriptor-lane macros plus one
//   point macro (index NL). Registers the macro pins and reassembles the
//   macro Q outputs back into a {point, descriptor} word.
//   Ports:
//     i_clk, i_rst_n : clock, asynchronous active-low reset
//     i_wr_en        : write this bank at i_addr with i_wr_data
//     i_rd_en        : read this bank at i_addr
//     i_addr         : entry index
//     i_wr_data      : {point, descriptor} word to store
//     o_wen          : registered active-low macro write enables
//     o_addr         : registered macro addresses
//     o_d            : registered macro write data (zero-extended)
//     i_q            : macro read data
//     o_rd_word      : reassembled word from i_q (combinational)
module match_mem_bank_if
    import match_mem_pkg::*;
#(
    parameter int POINT_W  = POINT_W_DEF,
    parameter int DESC_W   = DESC_W_DEF,
    parameter int LANE_W   = LANE_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    localparam int NL      = calc_nl(DESC_W, LANE_W),
    localparam int MW      = calc_mw(LANE_W, POINT_W),
    localparam int WORD_W  = POINT_W + DESC_W
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_wr_en,
    input  logic                         i_rd_en,
    input  logic [ADDR_W-1:0]            i_addr,
    input  logic [WORD_W-1:0]            i_wr_data,
    output logic [NL:0]                  o_wen,
    output logic [NL:0][ADDR_W-1:0]      o_addr,
    output logic [NL:0][MW-1:0]          o_d,
    input  logic [NL:0][MW-1:0]          i_q,
    output logic [WORD_W-1:0]            o_rd_word
);

    // Macro bits above the lane/point field carry nothing; fold them away.
    logic q_unused;
    assign q_unused = ^i_q;

    // Pin stage: address and data hold their last value when the bank is idle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wen  <= '1;
            o_addr <= '0;
            o_d    <= '0;
        end else begin
            o_wen <= {(NL+1){~i_wr_en}};
            if (i_wr_en || i_rd_en) begin
                for (int i = 0; i <= NL; i++) begin
                    o_addr[i] <= i_addr;
                end
            end
            if (i_wr_en) begin
                for (int i = 0; i < NL; i++) begin
                    o_d[i] <= MW'(i_wr_data[lane_lo(i, LANE_W) +: LANE_W]);
                end
                o_d[NL] <= MW'(i_wr_data[DESC_W +: POINT_W]);
            end
        end
    end

    always_comb begin
        o_rd_word = '0;
        for (int i = 0; i < NL; i++) begin
            o_rd_word[lane_lo(i, LANE_W) +: LANE_W] = i_q[i][LANE_W-1:0];
        end
        o_rd_word[DESC_W +: POINT_W] = i_q[NL][POINT_W-1:0];
    end

endmodule

// File: rtl/match_mem_pingpong.sv
// match_mem_pingpong
//   Ping-pong keypoint/descriptor store. The current frame is written at an
//   auto-incrementing address into bank cur_sel; the matcher reads the previous
//   frame from bank !cur_sel. i_swap exchanges the roles.
//   Ports:
//     i_clk, i_rst_n          : clock, asynchronous active-low reset
//     i_wr_valid/i_wr_data    : current-frame word, accepted when o_wr_ready
//     o_wr_ready              : low once the current bank holds DEPTH entries
//     i_rd_valid/i_rd_addr    : previous-frame read request (always accepted)
//     o_rd_valid/o_rd_data    : read response, SRAM_LAT+2 cycles after request
//     o_rd_oob                : request index was >= o_prev_cnt
//     i_swap                  : frame-boundary pulse
//     o_cur_cnt/o_prev_cnt    : entries in current / readable bank
//     o_sram_wen/addr/d, i_sram_q : macro pins, [bank][macro], macro NL = point
module match_mem_pingpong
    import match_mem_pkg::*;
#(
    parameter int POINT_W  = POINT_W_DEF,
    parameter int DESC_W   = DESC_W_DEF,
    parameter int LANE_W   = LANE_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int SRAM_LAT = SRAM_LAT_DEF,
    localparam int NL      = calc_nl(DESC_W, LANE_W),
    localparam int MW      = calc_mw(LANE_W, POINT_W),
    localparam int WORD_W  = POINT_W + DESC_W
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_wr_valid,
    input  logic [WORD_W-1:0]                  i_wr_data,
    output logic                               o_wr_ready,
    input  logic                               i_rd_valid,
    input  logic [ADDR_W-1:0]                  i_rd_addr,
    output logic                               o_rd_valid,
    output logic [WORD_W-1:0]                  o_rd_data,
    output logic                               o_rd_oob,
    input  logic                               i_swap,
    output logic [ADDR_W:0]                    o_cur_cnt,
    output logic [ADDR_W:0]                    o_prev_cnt,
    output logic [1:0][NL:0]                   o_sram_wen,
    output logic [1:0][NL:0][ADDR_W-1:0]       o_sram_addr,
    output logic [1:0][NL:0][MW-1:0]           o_sram_d,
    input  logic [1:0][NL:0][MW-1:0]           i_sram_q
);

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic              cur_sel;
    logic [ADDR_W:0]   cur_cnt;
    logic [ADDR_W:0]   prev_cnt;
    logic              wr_acc;

    logic [1:0][WORD_W-1:0] bank_word;

    // Read tag delay line: request capture (index 0) through Q-valid (index SRAM_LAT)
    logic vld_p  [SRAM_LAT+1];
    logic bank_p [SRAM_LAT+1];
    logic oob_p  [SRAM_LAT+1];

    assign o_wr_ready = (cur_cnt != FULL_CNT);
    assign wr_acc     = i_wr_valid && o_wr_ready;
    assign o_cur_cnt  = cur_cnt;
    assign o_prev_cnt = prev_cnt;

    // A write accepted in the swap cycle still belongs to the closing frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cur_sel  <= 1'b0;
            cur_cnt  <= '0;
            prev_cnt <= '0;
        end else if (i_swap) begin
            cur_sel  <= ~cur_sel;
            cur_cnt  <= '0;
            prev_cnt <= cur_cnt + {{ADDR_W{1'b0}}, wr_acc};
        end else if (wr_acc) begin
            cur_cnt <= cur_cnt + 1'b1;
        end
    end

    // Writes go to the current bank, reads to the other, so they never collide.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic              wr_en_b;
        logic              rd_en_b;
        logic [ADDR_W-1:0] addr_b;

        assign wr_en_b = wr_acc && (cur_sel == 1'(b));
        assign rd_en_b = i_rd_valid && (cur_sel != 1'(b));
        assign addr_b  = wr_en_b ? cur_cnt[ADDR_W-1:0] : i_rd_addr;

        match_mem_bank_if #(
            .POINT_W (POINT_W),
            .DESC_W  (DESC_W),
            .LANE_W  (LANE_W),
            .ADDR_W  (ADDR_W)
        ) u_bank (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_wr_en   (wr_en_b),
            .i_rd_en   (rd_en_b),
            .i_addr    (addr_b),
            .i_wr_data (i_wr_data),
            .o_wen     (o_sram_wen[b]),
            .o_addr    (o_sram_addr[b]),
            .o_d       (o_sram_d[b]),
            .i_q       (i_sram_q[b]),
            .o_rd_word (bank_word[b])
        );
    end

    // Tag stages: bank and oob are frozen at request so a swap cannot redirect them
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i <= SRAM_LAT; i++) begin
                vld_p[i]  <= 1'b0;
                bank_p[i] <= 1'b0;
                oob_p[i]  <= 1'b0;
            end
            o_rd_valid <= 1'b0;
            o_rd_oob   <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            vld_p[0]  <= i_rd_valid;
            bank_p[0] <= ~cur_sel;
            oob_p[0]  <= ({1'b0, i_rd_addr} >= prev_cnt);
            for (int i = 1; i <= SRAM_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                bank_p[i] <= bank_p[i-1];
                oob_p[i]  <= oob_p[i-1];
            end
            // Output stage
            o_rd_valid <= vld_p[SRAM_LAT];
            o_rd_oob   <= vld_p[SRAM_LAT] && oob_p[SRAM_LAT];
            if (vld_p[SRAM_LAT]) begin
                o_rd_data <= bank_word[bank_p[SRAM_LAT]];
            end
        end
    end

endmodule

// File: tb/tb_match_mem_pingpong.sv
// tb_match_mem_pingpong
//   Directed bench for match_mem_pingpong with behavioural SRAM macros
//   (one-cycle registered read, write on active-low wen).
module tb_match_mem_pingpong;

    localparam int POINT_W  = 30;
    localparam int DESC_W   = 256;
    localparam int LANE_W   = 32;
    localparam int ADDR_W   = 9;
    localparam int SRAM_LAT = 1;
    localparam int NL       = 8;
    localparam int MW       = 32;
    localparam int WORD_W   = 286;
    localparam int DEPTH    = 512;
    localparam int LAT      = 3;

    logic                          clk;
    logic                          i_rst_n;
    logic                          i_wr_valid;
    logic [WORD_W-1:0]             i_wr_data;
    logic                          o_wr_ready;
    logic                          i_rd_valid;
    logic [ADDR_W-1:0]             i_rd_addr;
    logic                          o_rd_valid;
    logic [WORD_W-1:0]             o_rd_data;
    logic                          o_rd_oob;
    logic                          i_swap;
    logic [ADDR_W:0]               o_cur_cnt;
    logic [ADDR_W:0]               o_prev_cnt;
    logic [1:0][NL:0]              o_sram_wen;
    logic [1:0][NL:0][ADDR_W-1:0]  o_sram_addr;
    logic [1:0][NL:0][MW-1:0]      o_sram_d;
    logic [1:0][NL:0][MW-1:0]      i_sram_q;

    match_mem_pingpong #(
        .POINT_W  (POINT_W),
        .DESC_W   (DESC_W),
        .LANE_W   (LANE_W),
        .ADDR_W   (ADDR_W),
        .SRAM_LAT (SRAM_LAT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_wr_valid  (i_wr_valid),
        .i_wr_data   (i_wr_data),
        .o_wr_ready  (o_wr_ready),
        .i_rd_valid  (i_rd_valid),
        .i_rd_addr   (i_rd_addr),
        .o_rd_valid  (o_rd_valid),
        .o_rd_data   (o_rd_data),
        .o_rd_oob    (o_rd_oob),
        .i_swap      (i_swap),
        .o_cur_cnt   (o_cur_cnt),
        .o_prev_cnt  (o_prev_cnt),
        .o_sram_wen  (o_sram_wen),
        .o_sram_addr (o_sram_addr),
        .o_sram_d    (o_sram_d),
        .i_sram_q    (i_sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural macros
    logic [MW-1:0] mem [2][NL+1][DEPTH];
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            for (int m = 0; m <= NL; m++) begin
                if (!o_sram_wen[b][m]) mem[b][m][o_sram_addr[b][m]] <= o_sram_d[b][m];
                i_sram_q[b][m] <= mem[b][m][o_sram_addr[b][m]];
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    logic mon_en = 1'b1;

    typedef struct {
        int                due;
        logic [WORD_W-1:0] word;
        logic              oob;
        logic              chk_data;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk_eq(input string tag, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] mk_word(input int k);
        logic [POINT_W-1:0] p;
        logic [DESC_W-1:0]  d;
        p = POINT_W'(32'h1000_0000 + k);
        for (int i = 0; i < NL; i++) d[i*LANE_W +: LANE_W] = LANE_W'(k);
        return {p, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input int k);
        i_wr_valid = 1'b1;
        i_wr_data  = mk_word(k);
        tick();
        i_wr_valid = 1'b0;
    endtask

    task automatic rd_req(input int addr, input logic [WORD_W-1:0] w, input logic oob, input logic cd);
        i_rd_valid = 1'b1;
        i_rd_addr  = ADDR_W'(addr);
        exp_q.push_back('{due: cyc + LAT, word: w, oob: oob, chk_data: cd});
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        chk_eq("rd_drain", WORD_W'(exp_q.size()), '0);
        exp_q.delete();
    endtask

    // Read response monitor
    always begin
        exp_t e;
        @(posedge clk);
        cyc++;
        #2;
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk_eq("rd_valid", o_rd_valid, 1'b1);
                chk_eq("rd_oob", o_rd_oob, e.oob);
                if (e.chk_data) chk_eq("rd_data", o_rd_data, e.word);
            end else if (o_rd_valid) begin
                chk_eq("rd_spurious", o_rd_valid, 1'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_wr_valid = 1'b0; i_wr_data = '0; i_rd_valid = 1'b0;
        i_rd_addr = '0; i_swap = 1'b0;
        repeat (3) tick();
        i_rst_n = 1'b1;
        tick();

        // Reset state
        chk_eq("rst_wen", o_sram_wen, {18{1'b1}});
        chk_eq("rst_ready", o_wr_ready, 1'b1);
        chk_eq("rst_cur_cnt", o_cur_cnt, '0);
        chk_eq("rst_prev_cnt", o_prev_cnt, '0);
        chk_eq("rst_rd_valid", o_rd_valid, 1'b0);
        chk_eq("rst_rd_data", o_rd_data, '0);
        chk_eq("rst_addr_zero", (o_sram_addr == '0), 1'b1);
        chk_eq("rst_d_zero", (o_sram_d == '0), 1'b1);

        // Read of empty previous bank is out of bounds
        rd_req(0, '0, 1'b1, 1'b0);
        tick();
        i_rd_valid = 1'b0;
        drain();

        // Frame of 5 words into bank 0
        for (int k = 0; k < 5; k++) begin
            wr_word(k);
            if (k == 3) begin
                chk_eq("wr_pin_wen", o_sram_wen[0], 9'h000);
                chk_eq("wr_pin_addr", o_sram_addr[0][NL], 9'd3);
                chk_eq("wr_pin_point", o_sram_d[0][NL], 32'h1000_0003);
                chk_eq("wr_pin_lane5", o_sram_d[0][5], 32'd3);
                chk_eq("idle_bank_wen", o_sram_wen[1], 9'h1ff);
                chk_eq("wr_cur_cnt", o_cur_cnt, 10'd4);
            end
        end
        i_swap = 1'b1;
        tick();
        i_swap = 1'b0;
        chk_eq("swap_prev_cnt5", o_prev_cnt, 10'd5);
        chk_eq("swap_cur_cnt0", o_cur_cnt, 10'd0);
        for (int k = 0; k < 5; k++) begin
            rd_req(k, mk_word(k), 1'b0, 1'b1);
            tick();
        end
        rd_req(5, '0, 1'b1, 1'b0);
        tick();
        i_rd_valid = 1'b0;
        drain();

        // Write accepted in the swap cycle as 4th word (bank 1)
        wr_word(10); wr_word(11); wr_word(12);
        i_wr_valid = 1'b1; i_wr_data = mk_word(13); i_swap = 1'b1;
        tick();
        i_wr_valid = 1'b0; i_swap = 1'b0;
        chk_eq("swapwr_prev_cnt", o_prev_cnt, 10'd4);
        chk_eq("swapwr_cur_cnt", o_cur_cnt, 10'd0);
        for (int k = 3; k >= 0; k--) begin
            rd_req(k, mk_word(10 + k), 1'b0, 1'b1);
            tick();
        end
        i_rd_valid = 1'b0;
        drain();

        // Reads straddling a swap keep their original bank
        wr_word(20); wr_word(21);
        rd_req(1, mk_word(11), 1'b0, 1'b1);
        tick();
        rd_req(2, mk_word(12), 1'b0, 1'b1);
        i_swap = 1'b1;
        tick();
        i_swap = 1'b0;
        rd_req(0, mk_word(20), 1'b0, 1'b1);
        tick();
        rd_req(2, '0, 1'b1, 1'b0);
        tick();
        i_rd_valid = 1'b0;
        chk_eq("straddle_prev_cnt", o_prev_cnt, 10'd2);
        drain();

        // Fill bank 1 to DEPTH, then one dropped write
        i_wr_valid = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            i_wr_data = mk_word(100 + i);
            tick();
            if (i == DEPTH - 2) begin
                chk_eq("full_m1_ready", o_wr_ready, 1'b1);
                chk_eq("full_m1_cnt", o_cur_cnt, 10'd511);
            end
            if (i == DEPTH - 1) begin
                chk_eq("full_ready", o_wr_ready, 1'b0);
                chk_eq("full_cnt", o_cur_cnt, 10'd512);
            end
            if (i == DEPTH) begin
                chk_eq("full_drop_cnt", o_cur_cnt, 10'd512);
                chk_eq("full_drop_wen", o_sram_wen[1], 9'h1ff);
            end
        end
        i_wr_valid = 1'b0;
        i_swap = 1'b1;
        tick();
        i_swap = 1'b0;
        chk_eq("full_prev_cnt", o_prev_cnt, 10'd512);
        rd_req(0, mk_word(100), 1'b0, 1'b1);
        tick();
        rd_req(511, mk_word(611), 1'b0, 1'b1);
        tick();
        i_rd_valid = 1'b0;
        drain();

        // Reset with reads in flight
        mon_en = 1'b0;
        i_rd_valid = 1'b1;
        i_rd_addr = 9'd0; tick();
        i_rd_addr = 9'd1; tick();
        i_rd_addr = 9'd2; tick();
        i_rd_valid = 1'b0;
        chk_eq("pre_rst_valid", o_rd_valid, 1'b1);
        chk_eq("pre_rst_data", o_rd_data, mk_word(100));
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_eq("async_rst_valid", o_rd_valid, 1'b0);
        chk_eq("async_rst_cur_cnt", o_cur_cnt, '0);
        chk_eq("async_rst_wen", o_sram_wen, {18{1'b1}});
        @(posedge clk);
        @(posedge clk);
        #3;
        i_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_eq("no_vld_after_rst", o_rd_valid, 1'b0);
        end
        mon_en = 1'b1;

        // Bank contents survive reset
        rd_req(5, mk_word(105), 1'b1, 1'b1);
        tick();
        i_rd_valid = 1'b0;
        drain();
        i_swap = 1'b1;
        tick();
        i_swap = 1'b0;
        chk_eq("reswap_prev_cnt", o_prev_cnt, '0);
        rd_req(0, mk_word(20), 1'b1, 1'b1);
        tick();
        i_rd_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/match_mem_pingpong.md
# match_mem_pingpong

Parametrised ping-pong keypoint/descriptor store between the feature extractor and the matcher. Incoming (point, descriptor) words for the current frame are written at an auto-incrementing address into one physical bank. The matcher reads the previous frame from the other bank. A swap pulse exchanges bank roles at the frame boundary. Each bank is striped across one point SRAM macro and NL descriptor-lane macros, with registered macro pins and registered read data.

## Interface
- POINT_W, 30, keypoint field width (word MSBs)
- DESC_W, 256, descriptor width (word LSBs)
- LANE_W, 32, descriptor macro width; NL = DESC_W/LANE_W, must divide exactly
- ADDR_W, 9, macro address width; DEPTH = 2**ADDR_W entries per bank
- SRAM_LAT, 1, macro read latency in cycles (Q valid SRAM_LAT cycles after address at pin)
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_wr_valid  in  1  current-frame word valid
- i_wr_data  in  POINT_W+DESC_W  {point, descriptor}
- o_wr_ready  out  1  write accepted when valid&&ready
- i_rd_valid  in  1  previous-frame read request (port always ready)
- i_rd_addr  in  ADDR_W  read index
- o_rd_valid  out  1  read data valid
- o_rd_data  out  POINT_W+DESC_W  read word
- o_rd_oob  out  1  with o_rd_valid: i_rd_addr was >= o_prev_cnt
- i_swap  in  1  one-cycle frame-boundary pulse
- o_cur_cnt  out  ADDR_W+1  entries written this frame
- o_prev_cnt  out  ADDR_W+1  entries in readable bank
- o_sram_wen  out  [2][NL+1]  active-low write enable; index NL = point macro
- o_sram_addr  out  [2][NL+1][ADDR_W]  macro address
- o_sram_d  out  [2][NL+1][max(LANE_W,POINT_W)]  macro write data, zero-extended
- i_sram_q  in  [2][NL+1][max(LANE_W,POINT_W)]  macro read data

## Operation
- Reset: cur_sel=0 (bank 0 current, bank 1 previous); o_cur_cnt=0, o_prev_cnt=0, o_rd_valid=0, o_rd_oob=0, o_rd_data=0, o_wr_ready=1, all o_sram_wen=1 (no write), o_sram_addr=0, o_sram_d=0.
- Write: address = o_cur_cnt[ADDR_W-1:0] in bank cur_sel; o_cur_cnt++ on accept. o_wr_ready = (o_cur_cnt != DEPTH). Full: writes dropped, count saturates at DEPTH.
- Lane split: lane i gets word[LANE_W*i +: LANE_W]. Point macro gets word[DESC_W +: POINT_W]. Read reassembles in the same order.
- Read: always from bank !cur_sel. The bank select, oob flag and valid are captured at request and carried through the pipeline. An in-flight read therefore completes from its original bank across a swap.
- Reads and writes always target different banks, so there is no arbitration and both may issue every cycle.
- Idle bank cycle: wen=1; addr and d hold last value.
- Swap (i_swap=1 at edge): cur_sel toggles; o_prev_cnt <= o_cur_cnt + (write accepted same cycle ? 1 : 0). o_cur_cnt <= 0. A same-cycle write lands in the old current bank. A same-cycle read uses the old previous bank. i_swap held N cycles performs N swaps.
- Reset mid-frame: pipeline valids cleared immediately (async); bank contents are not cleared.

## Timing
- Cycle 0: request sampled. Edge 1: macro pins registered. Q valid after SRAM_LAT more cycles. Next edge: o_rd_data/o_rd_valid/o_rd_oob registered.
- Read latency = SRAM_LAT+2 cycles (3 at default). Full throughput, one read per cycle, order preserved.
- Write reaches macro pins 1 cycle after accept. o_wr_ready and o_cur_cnt update the cycle after accept.
- Read after swap of data written in the last frame: that data is visible to any request issued from the cycle after the swap edge. The write pin stage has already completed by then.

## Structure
- Package match_mem_pkg: the default parameter constants, NL/macro-width localparams derivation functions, and the lane bit-offset function.
- Sub-module match_mem_bank_if, instantiated twice:
  - Inputs: one write/read request.
  - Responsibilities: registers the NL+1 macro pin sets, performs the lane split, and reassembles Q.
- The top holds cur_sel, the counters, and the read-tag delay line (SRAM_LAT+1 stages of {valid, bank, oob}).

## Test plan
- Reset release -> all wen=1, o_wr_ready=1, counts 0; read addr 0 -> o_rd_valid at +3 cycles with o_rd_oob=1.
- Write 5 words (point=0x1000_0000+k, desc lanes=k) then swap; read addr 0..4 back-to-back -> five consecutive valid words matching, oob=0, o_prev_cnt=5, o_cur_cnt=0.
- Write DEPTH=512 words -> o_wr_ready low after 512th accept, 513th write ignored, o_cur_cnt=512.
- Write accepted in swap cycle as 4th word -> o_prev_cnt=4, word readable at addr 3 in new previous bank.
- Read issued 1 cycle before swap -> returns old previous-bank data despite swap; read issued in swap cycle also returns old-bank data.
- Assert i_rst_n low while 3 reads in flight -> o_rd_valid 0 immediately, no valid pulse after release; bank contents readable after re-swap sequence.
